// File: rtl/uncache_bridge.sv
// Uncached access bridge: takes one CPU uncached request at a time, holds it
// on the bus until accepted, waits for completion and returns a one-cycle
// completion pulse (with read data on reads) to the CPU.
// Optional feature macro: UNCACHE_WBUF_EN -- posted writes (CPU completion is
// signalled the cycle after acceptance while the bus drains the write).
module uncache_bridge (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_size,
    input  logic [3:0]  cpu_wstrb,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic [31:0] cpu_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

`ifdef UNCACHE_WBUF_EN
    localparam logic POSTED = 1'b1;
`else
    localparam logic POSTED = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state, state_nxt;
    req_t        req_q;
    logic [31:0] rdata_q;
    logic        post_q;
    logic        accept;

    assign accept = (state == S_IDLE) && cpu_req;

    // State register; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state: one outstanding transaction; stray bus handshakes ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (cpu_req)     state_nxt = S_REQ;
            S_REQ:  if (bus_addr_ok) state_nxt = S_WAIT;
            S_WAIT: if (bus_data_ok) state_nxt = (POSTED && req_q.wr) ? S_IDLE : S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; posted writes ack via post_q.
    always_comb begin
        cpu_addr_ok = (state == S_IDLE);
        bus_req     = (state == S_REQ);
        cpu_data_ok = (state == S_RESP) || post_q;
    end

    // Capture the accepted request; fields stay stable until the next accept.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_q <= '0;
        end else if (accept) begin
            req_q <= '{wr: cpu_wr, size: cpu_size, wstrb: cpu_wstrb,
                       addr: cpu_addr, wdata: cpu_wdata};
        end
    end

    // Read data is captured only by read completions, so it survives writes.
    always_ff @(posedge clk) begin
        if (!resetn)                                            rdata_q <= '0;
        else if (state == S_WAIT && bus_data_ok && !req_q.wr)  rdata_q <= bus_rdata;
    end

    // Early completion pulse for posted writes, one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (!resetn) post_q <= 1'b0;
        else         post_q <= POSTED && accept && cpu_wr;
    end

    assign cpu_rdata = rdata_q;
    assign bus_wr    = req_q.wr;
    assign bus_size  = req_q.size;
    assign bus_wstrb = req_q.wstrb;
    assign bus_addr  = req_q.addr;
    assign bus_wdata = req_q.wdata;

endmodule
